// File: rtl/nice_pkg.sv
// Shared definitions for the telemetry frame packer.
//   HEADER_WORD : frame sync word ("NICE")
//   N_CH_DEF    : default channel count (10 ADC + 2 OPD + 6 shear + 6 point)
//   FRAME_WORDS : words per frame at the default channel count
//   state_t     : packer FSM states
package nice_pkg;
  localparam int          N_CH_DEF    = 24;
  localparam logic [31:0] HEADER_WORD = 32'h4E494345;
  localparam int          FRAME_WORDS = N_CH_DEF + 3;

  typedef enum logic [2:0] {IDLE, HDR, CNT, DATA, CSUM} state_t;

  // header + counter + channels + checksum
  function automatic int frame_words(input int n_ch);
    return n_ch + 3;
  endfunction
endpackage

// File: rtl/telemetry_frame_packer.sv
// Snapshots the core's result channels and sample counter on each strobe and
// streams them out as one frame: HEADER, counter, ch[0..N_CH-1], XOR checksum.
// Ports:
//   clk, rst          clock, async active-high reset
//   sample_stb_i      one-cycle strobe: ch_i/counter_i valid this cycle
//   ch_i              flattened channels, channel k at [32k+31:32k]
//   counter_i         sample counter
//   m_data_o/m_valid_o/m_ready_i/m_last_o  valid/ready word stream, last = checksum
//   busy_o            frame in progress
//   dropped_o         saturating count of strobes lost while busy
module telemetry_frame_packer
  import nice_pkg::*;
#(
  parameter int          N_CH   = N_CH_DEF,
  parameter logic [31:0] HEADER = HEADER_WORD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_stb_i,
  input  logic [32*N_CH-1:0]   ch_i,
  input  logic [31:0]          counter_i,
  output logic [31:0]          m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 m_last_o,
  output logic                 busy_o,
  output logic [15:0]          dropped_o
);
  localparam int             IW       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IW-1:0]  IDX_LAST = IW'(N_CH - 1);

  state_t                  state, state_nxt;
  logic [N_CH-1:0][31:0]   snap;
  logic [31:0]             snap_cnt;
  logic [31:0]             acc, acc_nxt, data_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic                    xfer, start, drop;

  assign xfer = m_valid_o & m_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: if (sample_stb_i) begin state_nxt = HDR; start = 1'b1; end
      HDR:  if (xfer) state_nxt = CNT;
      CNT:  if (xfer) state_nxt = DATA;
      DATA: if (xfer && idx == IDX_LAST) state_nxt = CSUM;
      CSUM: if (xfer) begin
              // a strobe landing on the checksum handshake chains the next frame
              if (sample_stb_i) begin state_nxt = HDR; start = 1'b1; end
              else state_nxt = IDLE;
            end
      default: state_nxt = IDLE;
    endcase

    drop = sample_stb_i && (state != IDLE) && !(state == CSUM && xfer);

    idx_nxt = idx;
    if (start)                     idx_nxt = '0;
    else if (state == DATA && xfer) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    acc_nxt = acc;
    if (start)                      acc_nxt = '0;
    else if (xfer && state != CSUM) acc_nxt = acc ^ m_data_o;

    // Outputs are registered, so the word for the next state is chosen here.
    // While stalled every input to this mux is unchanged, so data holds.
    case (state_nxt)
      HDR:     data_nxt = HEADER;
      CNT:     data_nxt = snap_cnt;
      DATA:    data_nxt = snap[idx_nxt];
      CSUM:    data_nxt = acc_nxt;
      default: data_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap      <= '0;
      snap_cnt  <= '0;
      acc       <= '0;
      idx       <= '0;
      m_data_o  <= '0;
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      busy_o    <= 1'b0;
      dropped_o <= '0;
    end else begin
      if (start) begin
        snap     <= ch_i;
        snap_cnt <= counter_i;
      end
      acc       <= acc_nxt;
      idx       <= idx_nxt;
      m_data_o  <= data_nxt;
      m_valid_o <= (state_nxt != IDLE);
      m_last_o  <= (state_nxt == CSUM);
      busy_o    <= (state_nxt != IDLE);
      if (drop && dropped_o != 16'hFFFF) dropped_o <= dropped_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_telemetry_frame_packer.sv
// Self-checking bench for telemetry_frame_packer: directed steps with random
// channel data, checked against a frame model built from queues.
module tb_telemetry_frame_packer;
  localparam int          N_CH = 24;
  localparam int          FW   = N_CH + 3;
  localparam logic [31:0] HDRW = 32'h4E494345;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sample_stb_i = 1'b0;
  logic [32*N_CH-1:0]   ch_i = '0;
  logic [31:0]          counter_i = '0;
  logic [31:0]          m_data_o;
  logic                 m_valid_o;
  logic                 m_ready_i = 1'b0;
  logic                 m_last_o;
  logic                 busy_o;
  logic [15:0]          dropped_o;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  telemetry_frame_packer #(.N_CH(N_CH), .HEADER(HDRW)) dut (
    .clk(clk), .rst(rst), .sample_stb_i(sample_stb_i), .ch_i(ch_i),
    .counter_i(counter_i), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_last_o(m_last_o), .busy_o(busy_o),
    .dropped_o(dropped_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [32*N_CH-1:0] rand_ch();
    logic [32*N_CH-1:0] f;
    for (int k = 0; k < N_CH; k++) f[32*k +: 32] = $urandom();
    return f;
  endfunction

  // Reference frame: header, counter, channels in order, then XOR of all of them.
  task automatic build_exp(input logic [31:0] cnt, input logic [32*N_CH-1:0] flat);
    logic [31:0] x;
    exp_q.delete();
    exp_q.push_back(HDRW);
    exp_q.push_back(cnt);
    for (int k = 0; k < N_CH; k++) exp_q.push_back(flat[32*k +: 32]);
    x = '0;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
  endtask

  // Pulse the strobe for one cycle; returns at the negedge after the capture edge.
  task automatic do_strobe(input logic [31:0] cnt, input logic [32*N_CH-1:0] flat);
    @(negedge clk);
    counter_i = cnt; ch_i = flat; sample_stb_i = 1'b1;
    @(negedge clk);
    sample_stb_i = 1'b0;
    counter_i = ~cnt; ch_i = ~flat;
  endtask

  // Receive one frame and compare it with exp_q.
  task automatic recv_frame(input string tag, input int rdy_pct, input bit scramble,
                            input int stb_at, input bit b2b, input logic [31:0] b_cnt,
                            input logic [32*N_CH-1:0] b_ch, output int cycles);
    logic [31:0] expf[$];
    logic [31:0] held_d;
    logic        held_l, stalled, r;
    int          k;
    expf = exp_q;
    k = 0; cycles = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
    while (k < FW && cycles < 4000) begin
      sample_stb_i = 1'b0;
      if (scramble) begin ch_i = rand_ch(); counter_i = $urandom(); end
      chk({tag, ".valid"}, 32'(m_valid_o), 32'd1);
      if (stalled) begin
        chk({tag, ".hold_data"}, m_data_o, held_d);
        chk({tag, ".hold_last"}, 32'(m_last_o), 32'(held_l));
      end
      r = ($urandom_range(99) < rdy_pct);
      m_ready_i = r;
      stalled = m_valid_o && !r;
      held_d = m_data_o; held_l = m_last_o;
      if (m_valid_o && r) begin
        chk($sformatf("%s.word%0d", tag, k), m_data_o, expf[k]);
        chk($sformatf("%s.last%0d", tag, k), 32'(m_last_o), 32'(k == FW-1));
        k++;
        if (b2b && k == FW) begin
          sample_stb_i = 1'b1; counter_i = b_cnt; ch_i = b_ch;
        end
      end
      if (cycles == stb_at) begin
        sample_stb_i = 1'b1; counter_i = $urandom(); ch_i = rand_ch();
      end
      @(negedge clk);
      cycles++;
    end
    sample_stb_i = 1'b0;
    m_ready_i = 1'b0;
    chk({tag, ".words"}, 32'(k), 32'(FW));
  endtask

  initial begin
    logic [32*N_CH-1:0] f, f2;
    logic [31:0]        c, c2;
    int                 cyc;
    logic [15:0]        d0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst.valid", 32'(m_valid_o), 32'd0);
    chk("rst.data", m_data_o, 32'd0);
    chk("rst.last", 32'(m_last_o), 32'd0);
    chk("rst.busy", 32'(busy_o), 32'd0);
    chk("rst.dropped", 32'(dropped_o), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle.valid", 32'(m_valid_o), 32'd0);

    // single directed frame, ready held high
    for (int k = 0; k < N_CH; k++) f[32*k +: 32] = 32'h1000_0000 + 32'(k);
    build_exp(32'd5, f);
    do_strobe(32'd5, f);
    chk("single.busy", 32'(busy_o), 32'd1);
    chk("single.hdr_t1", m_data_o, HDRW);
    recv_frame("single", 100, 1'b0, -1, 1'b0, '0, '0, cyc);
    chk("single.cycles", 32'(cyc), 32'(FW));
    chk("single.idle", 32'(m_valid_o), 32'd0);

    // backpressure, random data
    for (int n = 0; n < 3; n++) begin
      f = rand_ch(); c = $urandom();
      build_exp(c, f);
      do_strobe(c, f);
      m_ready_i = 1'b0;
      recv_frame("bp", 50, 1'b0, -1, 1'b0, '0, '0, cyc);
    end

    // snapshot isolation: inputs churn every cycle during the frame
    f = rand_ch(); c = $urandom();
    build_exp(c, f);
    do_strobe(c, f);
    recv_frame("iso", 70, 1'b1, -1, 1'b0, '0, '0, cyc);
    chk("iso.dropped", 32'(dropped_o), 32'd0);

    // overrun: second strobe 5 cycles after the first
    f = rand_ch(); c = $urandom();
    build_exp(c, f);
    do_strobe(c, f);
    recv_frame("ovr", 100, 1'b0, 4, 1'b0, '0, '0, cyc);
    chk("ovr.dropped", 32'(dropped_o), 32'd1);
    @(negedge clk);
    chk("ovr.one_frame", 32'(m_valid_o), 32'd0);

    // back-to-back: strobe on the checksum handshake
    f = rand_ch(); c = $urandom();
    f2 = rand_ch(); c2 = $urandom();
    d0 = dropped_o;
    build_exp(c, f);
    do_strobe(c, f);
    recv_frame("b2b1", 60, 1'b0, -1, 1'b1, c2, f2, cyc);
    chk("b2b.valid_next", 32'(m_valid_o), 32'd1);
    chk("b2b.hdr_next", m_data_o, HDRW);
    chk("b2b.dropped", 32'(dropped_o), 32'(d0));
    build_exp(c2, f2);
    recv_frame("b2b2", 100, 1'b0, -1, 1'b0, '0, '0, cyc);
    chk("b2b2.cycles", 32'(cyc), 32'(FW));

    // reset in the middle of DATA (channel index 10 on the bus)
    f = rand_ch(); c = $urandom();
    do_strobe(c, f);
    m_ready_i = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort.idx10", m_data_o, f[32*10 +: 32]);
    #2 rst = 1'b1;
    #1;
    chk("abort.valid", 32'(m_valid_o), 32'd0);
    chk("abort.data", m_data_o, 32'd0);
    chk("abort.last", 32'(m_last_o), 32'd0);
    chk("abort.busy", 32'(busy_o), 32'd0);
    chk("abort.dropped", 32'(dropped_o), 32'd0);
    m_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    f = rand_ch(); c = $urandom();
    build_exp(c, f);
    do_strobe(c, f);
    recv_frame("fresh", 80, 1'b0, -1, 1'b0, '0, '0, cyc);

    // drop counter saturation while stalled on the header
    f = rand_ch(); c = $urandom();
    build_exp(c, f);
    do_strobe(c, f);
    @(negedge clk);
    sample_stb_i = 1'b1;
    repeat (70000) begin
      ch_i = ~ch_i; counter_i = counter_i + 1;
      @(negedge clk);
    end
    sample_stb_i = 1'b0;
    chk("sat.dropped", 32'(dropped_o), 32'h0000FFFF);
    chk("sat.hdr_held", m_data_o, HDRW);
    recv_frame("sat", 100, 1'b0, -1, 1'b0, '0, '0, cyc);
    chk("sat.dropped_after", 32'(dropped_o), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
